// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: PHT of 2-bit counters indexed by pc ^ GHR, a speculative
// global history register with mispredict repair, and a one-entry-per-cycle PHT initialiser.
//   state | meaning
//   INIT  | PHT entries written to weakly not-taken, one per cycle; predictions forced 0
//   RUN   | predict, shift speculative history, train and repair
module gshare_branch_predictor #(
    parameter int INDEX_BITS = 8,
    parameter int GHR_BITS   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         fetch_pc_i,
    input  logic                fetch_advance_i,
    output logic                predict_taken_o,
    output logic [GHR_BITS-1:0] predict_ghr_o,
    output logic                ready_o,
    input  logic                update_valid_i,
    input  logic [31:0]         update_pc_i,
    input  logic [GHR_BITS-1:0] update_ghr_i,
    input  logic                update_taken_i,
    input  logic                update_mispredict_i,
    output logic [31:0]         branch_count_o,
    output logic [31:0]         mispredict_count_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [31:0]           branch_cnt_q, branch_cnt_d;
    logic [31:0]           mispred_cnt_q, mispred_cnt_d;
    logic [1:0]            pht_q [ENTRIES];

    logic                  run;
    logic [INDEX_BITS-1:0] fidx, uidx;
    logic [1:0]            pht_old, pht_new;
    logic [GHR_BITS-1:0]   ghr_spec, ghr_repair;
    logic                  do_update, do_repair;

    assign run       = (state_q == ST_RUN);
    assign fidx      = fetch_pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign uidx      = update_pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(update_ghr_i);
    assign do_update = run && update_valid_i;
    assign do_repair = do_update && update_mispredict_i;

    assign predict_taken_o    = run && pht_q[fidx][1];
    assign predict_ghr_o      = ghr_q;
    assign ready_o            = run;
    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispred_cnt_q;

    // Upper/lower PC bits do not take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i[31:INDEX_BITS+2], fetch_pc_i[1:0],
                              update_pc_i[31:INDEX_BITS+2], update_pc_i[1:0]};

    generate
        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_spec   = predict_taken_o;
            assign ghr_repair = update_taken_i;
        end else begin : g_ghrn
            assign ghr_spec   = {ghr_q[GHR_BITS-2:0], predict_taken_o};
            assign ghr_repair = {update_ghr_i[GHR_BITS-2:0], update_taken_i};
        end
    endgenerate

    always_comb begin
        pht_old = pht_q[uidx];
        if (update_taken_i) begin
            pht_new = (pht_old == 2'd3) ? 2'd3 : pht_old + 2'd1;
        end else begin
            pht_new = (pht_old == 2'd0) ? 2'd0 : pht_old - 2'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == '1) begin
                state_d = ST_RUN;
            end
        end else begin
            // Repair wins over a same-cycle speculative shift: that fetch is being flushed.
            if (do_repair) begin
                ghr_d = ghr_repair;
            end else if (fetch_advance_i) begin
                ghr_d = ghr_spec;
            end
            if (do_update) begin
                branch_cnt_d = branch_cnt_q + 32'd1;
            end
            if (do_repair) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_INIT;
            init_ptr_q    <= '0;
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // PHT has no reset; INIT rewrites every entry after each reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                pht_q[init_ptr_q] <= 2'b01;
            end else if (update_valid_i) begin
                pht_q[uidx] <= pht_new;
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor: a driver pushes expected outputs from an
// abstract model into a queue; a monitor pops and compares them each cycle.
module tb_gshare_branch_predictor;

    localparam int IB = 4;
    localparam int GB = 4;
    localparam int N  = 1 << IB;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   fetch_pc;
    logic          fetch_advance;
    logic          predict_taken;
    logic [GB-1:0] predict_ghr;
    logic          ready;
    logic          update_valid;
    logic [31:0]   update_pc;
    logic [GB-1:0] update_ghr;
    logic          update_taken;
    logic          update_mispredict;
    logic [31:0]   branch_count;
    logic [31:0]   mispredict_count;

    always #5 clk = ~clk;

    gshare_branch_predictor #(.INDEX_BITS(IB), .GHR_BITS(GB)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_pc_i         (fetch_pc),
        .fetch_advance_i    (fetch_advance),
        .predict_taken_o    (predict_taken),
        .predict_ghr_o      (predict_ghr),
        .ready_o            (ready),
        .update_valid_i     (update_valid),
        .update_pc_i        (update_pc),
        .update_ghr_i       (update_ghr),
        .update_taken_i     (update_taken),
        .update_mispredict_i(update_mispredict),
        .branch_count_o     (branch_count),
        .mispredict_count_o (mispredict_count)
    );

    typedef struct {
        bit          rdy;
        bit          pt;
        logic [31:0] ghr;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: counters as plain ints, readiness from cycles elapsed since reset.
    int          m_pht[N];
    int          m_ghr;
    int          m_ninit;
    logic [31:0] m_bc, m_mc;
    bit          m_valid = 1'b0;

    function automatic int idx_of(input logic [31:0] pc, input int g);
        return (int'(pc >> 2) & (N - 1)) ^ g;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready", {31'd0, ready}, {31'd0, e.rdy});
            chk("predict_taken", {31'd0, predict_taken}, {31'd0, e.pt});
            chk("predict_ghr", 32'(predict_ghr), e.ghr);
            chk("branch_count", branch_count, e.bc);
            chk("mispredict_count", mispredict_count, e.mc);
        end
    end

    task automatic cycle(input bit r, input bit fa, input logic [31:0] pc, input bit uv,
                         input logic [31:0] upc, input int ughr, input bit ut, input bit um);
        exp_t e;
        bit   rdy, pt;
        int   ui;
        rst               = r;
        fetch_advance     = fa;
        fetch_pc          = pc;
        update_valid      = uv;
        update_pc         = upc;
        update_ghr        = GB'(ughr);
        update_taken      = ut;
        update_mispredict = um;
        rdy = (m_ninit >= N);
        pt  = rdy && (m_pht[idx_of(pc, m_ghr)] >= 2);
        if (m_valid) begin
            e.rdy = rdy; e.pt = pt; e.ghr = 32'(m_ghr); e.bc = m_bc; e.mc = m_mc;
            exp_q.push_back(e);
        end
        if (r) begin
            m_valid = 1'b1;
            m_ninit = 0;
            m_ghr   = 0;
            m_bc    = 0;
            m_mc    = 0;
            foreach (m_pht[i]) m_pht[i] = 1;
        end else if (!rdy) begin
            m_ninit++;
        end else begin
            if (uv) begin
                ui = idx_of(upc, ughr & (N - 1));
                if (ut) m_pht[ui] = (m_pht[ui] < 3) ? m_pht[ui] + 1 : 3;
                else    m_pht[ui] = (m_pht[ui] > 0) ? m_pht[ui] - 1 : 0;
                m_bc++;
            end
            if (uv && um) begin
                m_ghr = ((ughr << 1) | int'(ut)) & ((1 << GB) - 1);
                m_mc++;
            end else if (fa) begin
                m_ghr = ((m_ghr << 1) | int'(pt)) & ((1 << GB) - 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        cycle(0, 0, pc, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        logic [31:0] rpc;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        // INIT: updates and fetches must be ignored
        for (int i = 0; i < N; i++) cycle(0, 1, $urandom & 32'hFC, 1, 32'h100, 0, 1, 1);
        idle(32'h100);

        // Training
        cycle(0, 0, 32'h100, 1, 32'h100, 0, 1, 0);
        cycle(0, 0, 32'h100, 1, 32'h100, 0, 1, 0);
        idle(32'h100);

        // Saturation
        for (int i = 0; i < 5; i++) cycle(0, 0, 32'h20, 1, 32'h20, 0, 1, 0);
        cycle(0, 0, 32'h20, 1, 32'h20, 0, 0, 0);
        idle(32'h20);
        cycle(0, 0, 32'h20, 1, 32'h20, 0, 0, 0);
        cycle(0, 0, 32'h20, 1, 32'h20, 0, 0, 0);
        idle(32'h20);

        // Speculative shift then repair
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h4, 0, 0, 0, 0, 0);
        cycle(0, 0, 32'h4, 1, 32'h8, 5, 1, 1);
        idle(32'h4);

        // Repair wins over same-cycle fetch_advance
        cycle(0, 1, 32'h100, 1, 32'hC, 3, 0, 1);
        idle(32'h100);

        // Same-index read during update sees pre-update value
        g = m_ghr;
        cycle(0, 0, 32'h140, 1, 32'h140, g, 1, 0);
        cycle(0, 0, 32'h140, 1, 32'h140, g, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'h140, 1, 32'h140, g, 0, 0);
        idle(32'h140);

        // Reset mid-INIT
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) idle(32'h100);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < N + 1; i++) idle(32'h100);
        for (int i = 0; i < N; i++) idle(32'(i) << 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom & 32'h1FC;
            if ($urandom_range(0, 199) == 0) begin
                cycle(1, 0, rpc, 0, 0, 0, 0, 0);
            end else begin
                cycle(0, $urandom_range(0, 1), rpc, $urandom_range(0, 1),
                      ($urandom_range(0, 1) != 0) ? rpc : ($urandom & 32'h1FC),
                      ($urandom_range(0, 1) != 0) ? m_ghr : int'($urandom_range(0, N - 1)),
                      $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
            end
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
